// File: rtl/pipelined_adder_if.sv
// Operand/result handshake bundle for pipelined_adder; master drives operands, slave is the adder.
// The sub signal exists only when ADDER_SUB_EN is defined.
interface pipelined_adder_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
`ifdef ADDER_SUB_EN
  logic             sub;
`endif
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (
    output in_valid, a, b, cin, out_ready,
    input  in_ready, out_valid, sum, cout, ovf
`ifdef ADDER_SUB_EN
    , output sub
`endif
  );

  modport slave (
    input  in_valid, a, b, cin, out_ready,
    output in_ready, out_valid, sum, cout, ovf
`ifdef ADDER_SUB_EN
    , input sub
`endif
  );
endinterface

// File: rtl/pipelined_adder.sv
// Pipelined ripple-carry adder: STAGES-edge latency, one beat per cycle; an output stall freezes every stage and drops in_ready.
// Define ADDER_SUB_EN to add the sub port (result a - b - cin, cout=1 meaning no borrow).
module pipelined_adder #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  pipelined_adder_if.slave bus
);
  localparam int CHUNK = WIDTH / STAGES;

  typedef struct packed {
    logic             vld;
    logic [WIDTH-1:0] s;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             c;
    logic             a_msb;
    logic             b_msb;
  } stage_t;

  stage_t           stage_q  [STAGES];
  stage_t           stage_d  [STAGES];
  stage_t           stage_in [STAGES];
  logic [CHUNK:0]   cy       [STAGES];
  stage_t           entry;
  stage_t           tail;
  logic [WIDTH-1:0] b_eff;
  logic             c0;
  logic             stall;
  logic             unused_tail;

  function automatic logic [1:0] full_add(input logic x, input logic y, input logic ci);
    return {(x & y) | (ci & (x ^ y)), x ^ y ^ ci};
  endfunction

  // Subtraction is folded into the operand at entry, so the beat carries B' and C0 from here on.
  always_comb begin
`ifdef ADDER_SUB_EN
    b_eff = bus.sub ? ~bus.b   : bus.b;
    c0    = bus.sub ? ~bus.cin : bus.cin;
`else
    b_eff = bus.b;
    c0    = bus.cin;
`endif
  end

  always_comb begin
    entry       = '0;
    entry.vld   = bus.in_valid;
    entry.a     = bus.a;
    entry.b     = b_eff;
    entry.c     = c0;
    entry.a_msb = bus.a[WIDTH-1];
    entry.b_msb = b_eff[WIDTH-1];
  end

  always_comb begin
    stage_in[0] = entry;
    for (int s = 1; s < STAGES; s++) begin
      stage_in[s] = stage_q[s-1];
    end
  end

  // Each stage ripples one chunk and zeroes the operand bits it consumed.
  always_comb begin
    for (int s = 0; s < STAGES; s++) begin
      stage_d[s] = stage_in[s];
      cy[s][0]   = stage_in[s].c;
      for (int j = 0; j < CHUNK; j++) begin
        {cy[s][j+1], stage_d[s].s[s*CHUNK+j]} =
          full_add(stage_in[s].a[s*CHUNK+j], stage_in[s].b[s*CHUNK+j], cy[s][j]);
        stage_d[s].a[s*CHUNK+j] = 1'b0;
        stage_d[s].b[s*CHUNK+j] = 1'b0;
      end
      stage_d[s].c = cy[s][CHUNK];
    end
  end

  assign tail  = stage_q[STAGES-1];
  assign stall = tail.vld & ~bus.out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < STAGES; s++) begin
        stage_q[s] <= '0;
      end
    end else if (!stall) begin
      for (int s = 0; s < STAGES; s++) begin
        if (stage_d[s].vld) begin
          stage_q[s] <= stage_d[s];
        end else begin
          stage_q[s].vld <= 1'b0;
        end
      end
    end
  end

  assign bus.in_ready  = ~stall;
  assign bus.out_valid = tail.vld;
  assign bus.sum       = tail.s;
  assign bus.cout      = tail.c;
  assign bus.ovf       = (tail.a_msb == tail.b_msb) && (tail.s[WIDTH-1] != tail.a_msb);

  // Operand fields are fully consumed by the last stage.
  assign unused_tail = ^{tail.a, tail.b};
endmodule

// File: tb/tb_pipelined_adder.sv
// Scoreboard bench for pipelined_adder (WIDTH=8, STAGES=2): randomized and directed beats vs. an arithmetic model.
`timescale 1ns/1ps
module tb_pipelined_adder;
  localparam int W = 8;
  localparam int S = 2;

  typedef struct {
    logic [7:0] sum;
    logic       cout;
    logic       ovf;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   cyc   = 0;
  int   checks    = 0;
  int   failures  = 0;
  int   stall_cnt = 0;
  bit   drv_sub   = 1'b0;
  bit   held_vld  = 1'b0;
  exp_t held;
  exp_t exp_q[$];
  int   pop_cyc[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  pipelined_adder_if #(.WIDTH(W)) bus ();
  pipelined_adder #(.WIDTH(W), .STAGES(S)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(string name, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
    end
  endtask

  function automatic exp_t model(int a, int b, bit cin, bit sub);
    exp_t e;
    int bp, c0, u, sa, sb, sv;
    bp = sub ? 255 - b : b;
    c0 = sub ? 1 - int'(cin) : int'(cin);
    u  = a + bp + c0;
    sa = (a  >= 128) ? a  - 256 : a;
    sb = (bp >= 128) ? bp - 256 : bp;
    sv = sa + sb + c0;
    e.sum  = 8'(u % 256);
    e.cout = (u >= 256);
    e.ovf  = (sv > 127) || (sv < -128);
    return e;
  endfunction

  always @(negedge rst_n) exp_q.delete();

  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      held_vld = 1'b0;
    end else begin
      if (bus.in_valid && bus.in_ready)
        exp_q.push_back(model(int'(bus.a), int'(bus.b), bus.cin, drv_sub));
      if (bus.out_valid) begin
        if (held_vld) begin
          check("hold_sum",  32'(bus.sum),  32'(held.sum));
          check("hold_cout", 32'(bus.cout), 32'(held.cout));
          check("hold_ovf",  32'(bus.ovf),  32'(held.ovf));
        end
        if (!bus.out_ready) begin
          check("stall_in_ready", 32'(bus.in_ready), 32'd0);
          held_vld  = 1'b1;
          held.sum  = bus.sum;
          held.cout = bus.cout;
          held.ovf  = bus.ovf;
        end else begin
          held_vld = 1'b0;
          pop_cyc.push_back(cyc);
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_result: got sum 0x%0h with no beat outstanding", bus.sum);
          end else begin
            e = exp_q.pop_front();
            check("res_sum",  32'(bus.sum),  32'(e.sum));
            check("res_cout", 32'(bus.cout), 32'(e.cout));
            check("res_ovf",  32'(bus.ovf),  32'(e.ovf));
          end
        end
      end else begin
        held_vld = 1'b0;
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 just after the accepting edge.
  task automatic send(int a, int b, bit cin, bit sub);
    bit done = 1'b0;
    bus.in_valid = 1'b1;
    bus.a        = 8'(a);
    bus.b        = 8'(b);
    bus.cin      = cin;
    drv_sub      = sub;
`ifdef ADDER_SUB_EN
    bus.sub      = sub;
`endif
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        done = 1'b1;
        break;
      end
      stall_cnt++;
    end
    if (!done) begin
      checks++;
      failures++;
      $display("FAIL send_timeout: in_ready stayed 0, required 1 within 100 cycles");
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic directed(string name, int a, int b, bit cin, bit sub, int esum, bit ecout, bit eovf);
    int k = 0;
    send(a, b, cin, sub);
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (bus.out_valid) begin
        k = i;
        break;
      end
    end
    check({name, "_latency"}, 32'(k), 32'(S));
    if (k != 0) begin
      check({name, "_sum"},  32'(bus.sum),  32'(esum));
      check({name, "_cout"}, 32'(bus.cout), 32'(ecout));
      check({name, "_ovf"},  32'(bus.ovf),  32'(eovf));
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain(string name);
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !bus.out_valid) break;
    end
    check({name, "_drained"}, 32'(exp_q.size()), 32'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.cin       = 1'b0;
    bus.out_ready = 1'b1;
`ifdef ADDER_SUB_EN
    bus.sub       = 1'b0;
`endif
    #1;
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_in_ready",  32'(bus.in_ready),  32'd1);
    check("rst_sum",       32'(bus.sum),       32'd0);
    check("rst_cout",      32'(bus.cout),      32'd0);
    check("rst_ovf",       32'(bus.ovf),       32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;

    directed("chunk_carry", 8'h0F, 8'h01, 1'b0, 1'b0, 8'h10, 1'b0, 1'b0);
    directed("carry_out",   8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    directed("signed_ovf",  8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1);
`ifdef ADDER_SUB_EN
    directed("sub_neg",     8'h05, 8'h07, 1'b0, 1'b1, 8'hFE, 1'b0, 1'b0);
    directed("sub_ovf",     8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1);
`endif

    // Back-to-back stream with no back-pressure.
    pop_cyc.delete();
    stall_cnt = 0;
    for (int i = 0; i < 8; i++) send(i, 2 * i, i[0], 1'b0);
    drain("stream");
    check("stream_count", 32'(pop_cyc.size()), 32'd8);
    if (pop_cyc.size() == 8) check("stream_gapless", 32'(pop_cyc[7] - pop_cyc[0]), 32'd7);
    check("stream_in_ready_stalls", 32'(stall_cnt), 32'd0);

    // Stream with a 5-cycle out_ready drop.
    pop_cyc.delete();
    stall_cnt = 0;
    fork
      for (int i = 0; i < 12; i++)
        send(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), 1'b0);
      begin
        repeat (3) @(posedge clk);
        #1 bus.out_ready = 1'b0;
        repeat (5) @(posedge clk);
        #1 bus.out_ready = 1'b1;
      end
    join
    drain("bp");
    check("bp_count", 32'(pop_cyc.size()), 32'd12);
    check("bp_in_ready_dropped", 32'(stall_cnt > 0), 32'd1);

    // Random operands with random back-pressure.
    pop_cyc.delete();
    fork
      for (int i = 0; i < 40; i++) begin
        bit rs;
`ifdef ADDER_SUB_EN
        rs = 1'($urandom_range(0, 1));
`else
        rs = 1'b0;
`endif
        send(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), rs);
      end
      begin
        repeat (70) begin
          @(posedge clk);
          #1 bus.out_ready = ($urandom_range(0, 3) != 0);
        end
        bus.out_ready = 1'b1;
      end
    join
    bus.out_ready = 1'b1;
    drain("rand");
    check("rand_count", 32'(pop_cyc.size()), 32'd40);

    // Reset with two beats held in the pipe.
    bus.out_ready = 1'b0;
    send(8'h11, 8'h22, 1'b1, 1'b0);
    send(8'h33, 8'h44, 1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    check("mrst_out_valid", 32'(bus.out_valid), 32'd0);
    check("mrst_sum",       32'(bus.sum),       32'd0);
    check("mrst_cout",      32'(bus.cout),      32'd0);
    check("mrst_ovf",       32'(bus.ovf),       32'd0);
    check("mrst_in_ready",  32'(bus.in_ready),  32'd1);
    bus.out_ready = 1'b1;
    pop_cyc.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    check("mrst_in_ready_release", 32'(bus.in_ready), 32'd1);
    repeat (5) @(negedge clk);
    check("mrst_no_stale", 32'(pop_cyc.size()), 32'd0);
    @(posedge clk);
    #1;
    directed("post_reset", 8'h40, 8'h40, 1'b1, 1'b0, 8'h81, 1'b0, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/pipelined_adder.md
# pipelined_adder

- Parametrised, pipelined WIDTH-bit ripple-carry adder built from per-bit full-adder logic.
- The carry chain is split into STAGES equal chunks with one register stage per chunk, so wide adds close timing at full clock rate.
- Operands enter and results leave through valid/ready handshakes with full back-pressure.
- It is the datapath adder used by the team's wider arithmetic blocks in place of single-cycle ripple chains.

## Interface
Parameters:
- WIDTH, 16, operand and sum width in bits (≥2).
- STAGES, 4, number of pipeline stages. WIDTH must be divisible by STAGES; CHUNK = WIDTH/STAGES bits are added per stage.

Ports:
- clk  input  1  single clock, rising-edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  operand beat present.
- in_ready  output  1  adder can accept a beat this cycle.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- cin  input  1  carry-in (borrow-in when subtracting).
- sub  input  1  subtract select; present only when ADDER_SUB_EN is defined.
- out_valid  output  1  result beat present.
- out_ready  input  1  downstream accepts the result.
- sum  output  WIDTH  result, modulo 2^WIDTH.
- cout  output  1  carry out of the MSB.
- ovf  output  1  signed (two's-complement) overflow.

## Operation
- Effective operand: B' = b and C0 = cin, except in subtract mode (see Configuration).
- Stage k (1..STAGES) registers the following:
  - the low k·CHUNK sum bits;
  - the unsummed upper operand bits of a and B';
  - the running carry;
  - a valid bit.
- Stage 1 adds chunk 0 with C0. Stage k adds chunk k-1 using the carry from stage k-1.
- Final stage outputs:
  - sum = accumulated sum bits;
  - cout = final carry;
  - ovf = (a[MSB] == B'[MSB]) && (sum[MSB] != a[MSB]).
- The MSB operand bits needed for ovf are carried down the pipe.
- Stall rule: stall = out_valid && !out_ready.
  - When stall is high, no stage register updates.
  - When stall is low, every stage shifts forward by one.
  - Bubbles (valid=0) shift like data.
- in_ready = !stall (combinational). A beat is accepted when in_valid && in_ready.
- A result is consumed when out_valid && out_ready. A new result may be presented in the same cycle.
- Stage data registers load only when the incoming valid is 1; payload of bubbles is don't-care.
- Reset (asynchronous, any time):
  - all stage valid bits clear and all data registers clear to 0;
  - in-flight beats are discarded;
  - out_valid=0, sum=0, cout=0, ovf=0;
  - in_ready=1 while rst_n is low and immediately after release.

## Timing
- Latency: a beat accepted at rising edge t gives out_valid=1 after edge t+STAGES-1, i.e. visible in the cycle following the STAGES-th edge counting the accepting edge.
  - STAGES=1 gives a single registered add.
- Throughput: one beat per cycle with out_ready held high. No bubbles are inserted.
- While out_ready is low with out_valid high:
  - sum, cout and ovf hold stable;
  - in_ready is 0;
  - up to STAGES beats are held in the pipe without loss.
- When out_ready rises while in_valid is high, the output advance and the input accept happen on the same edge.
- The combinational path from out_ready to in_ready is the only input-to-output path.

## Configuration
- Macro: ADDER_SUB_EN.
- Defined:
  - The sub port exists and travels with the beat.
  - When sub=1: B' = ~b and C0 = ~cin, so the result is a − b − cin.
  - cout is the raw carry, where 1 means no borrow.
  - ovf uses B'.
- Undefined:
  - The sub port is absent.
  - The block always adds: B' = b, C0 = cin.
  - Behaviour is otherwise identical.

## Test plan
Bench configuration: WIDTH=8, STAGES=2.
- Carry across the chunk boundary: a=0x0F, b=0x01, cin=0 -> sum=0x10, cout=0, ovf=0, out_valid exactly 2 edges after accept.
- Full carry out: a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1, ovf=0. With a=0x7F, b=0x01 -> sum=0x80, cout=0, ovf=1.
- Streaming: 8 back-to-back beats (a=i, b=2i, cin=i[0]) with out_ready=1 -> 8 consecutive results a+b+cin in order, no gaps, in_ready constant 1.
- Back-pressure: out_ready=0 for 5 cycles during streaming -> in_ready=0 once the pipe fills, outputs held stable, no beat lost or duplicated after out_ready returns to 1.
- Mid-flight reset: rst_n pulsed low with 2 beats in flight -> out_valid=0 and sum/cout/ovf=0 immediately, in_ready=1, no stale result after release.
- With ADDER_SUB_EN defined: a=0x05, b=0x07, cin=0, sub=1 -> sum=0xFE, cout=0, ovf=0. With a=0x80, b=0x01, sub=1 -> sum=0x7F, cout=1, ovf=1.
